pipe_cleaner: RTL and testbench
===============================

Name: pipe_cleaner

Overview:
Parametrised elastic pipeline, the next generation of the team's fixed pipeline-cleaner block. WIDTH and DEPTH are configurable. Each stage carries a valid bit; bubbles are squeezed out (a stage advances whenever its successor is empty, even while the output is stalled). A single-cycle flush clears every stage. A drain FSM blocks new input until the pipe empties, then pulses a completion flag. The block sits between the TT pin wrapper's input capture and the output logic.

Parameters:
WIDTH, 8, data bits per stage
DEPTH, 4, number of register stages (legal range 1..16)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream data valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  payload of last stage
flush  input  1  clear all stages next cycle
drain_req  input  1  request drain (sampled in RUN only)
drained  output  1  one-cycle pulse: drain completed
occupancy  output  $clog2(DEPTH+1)  count of valid stages
empty  output  1  occupancy==0
full  output  1  occupancy==DEPTH

Behaviour:
- Reset (async, rst_n=0): all stage valids=0, stage data=0, out_valid=0, out_data=0, occupancy=0, drained=0, FSM=RUN. Release is synchronous to clk.
- Stage chain: stage 0 is input, stage DEPTH-1 is output. The ready chain is r[DEPTH]=out_ready and r[i]=!v[i] | r[i+1]. Stage i loads from stage i-1 (stage 0 loads from input) when r[i]. The load copies valid and data; a loaded bubble copies v=0 and leaves data don't-care, held.
- in_ready = r[0] & (FSM==RUN) & !flush. An input is accepted iff in_valid & in_ready.
- Latency: into an empty pipe, an accepted word appears on out_valid exactly DEPTH cycles later. Throughput is 1 word/cycle with out_ready held high.
- Bubble squeeze: with out_ready=0, words advance until contiguous at the output end. full asserts only when all DEPTH stages are valid.
- flush: next cycle all v=0 and occupancy=0, regardless of out_ready. No input is accepted in the flush cycle. A handshake completing in the flush cycle (out_valid & out_ready) still counts as delivered. Stage data is not cleared.
- occupancy is registered and updated each cycle by +accept -deliver. flush forces it to 0. It never wraps.
- FSM states:
  - RUN: drain_req=1 -> DRAIN.
  - DRAIN: input blocked; pipeline keeps delivering. When occupancy==0 -> DONE.
  - DONE: drained=1 for this one cycle; input blocked; -> RUN.
- drain_req is ignored in DRAIN and DONE. drain_req on an already empty pipe goes RUN->DRAIN->DONE, so drained pulses 2 cycles after the request.
- flush during DRAIN empties the pipe; the FSM reaches DONE on the following cycle.
- flush and drain_req in the same RUN cycle: both take effect (pipe cleared, FSM->DRAIN).
- Reset mid-drain: returns to RUN with no drained pulse.

Optional Feature:
PIPE_CLEANER_STATS_EN
- Defined: adds output flushed_cnt [15:0], reset 0. Each flush cycle adds the occupancy at that cycle minus any word delivered in that cycle; the counter saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package pipe_cleaner_pkg holds:
  - FSM state encodings (RUN=2'd0, DRAIN=2'd1, DONE=2'd2)
  - occupancy-width function
  - stats counter width constant
- One natural sub-module: pipe_cleaner_stage, which holds valid + WIDTH data with load/clear inputs. It is instantiated DEPTH times by a generate loop. The top owns the ready chain, occupancy and FSM.

Test Plan:
- DEPTH=4, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_valid at cycles 4,5,6 with 0x11,0x22,0x33; occupancy peaks at 3; empty returns high.
- out_ready=0, push 6 words -> 4 accepted, in_ready=0 after the 4th, full=1, occupancy=4. Raise out_ready -> words delivered in order with no loss.
- Push 0xAA, 2 idle cycles, push 0xBB with out_ready=0 -> both words are adjacent in the last two stages after 4 cycles (bubble squeezed); occupancy=2.
- Fill 3 words, assert flush for 1 cycle with out_ready=0 -> next cycle out_valid=0, occupancy=0, empty=1. With STATS_EN, flushed_cnt=3.
- Fill 2 words, drain_req pulse, out_ready=1 -> in_ready stays 0 while in_valid=1. drained pulses exactly once, the cycle after the last delivery; in_ready recovers the next cycle.
- Assert rst_n=0 asynchronously mid-DRAIN with 2 words in flight -> all outputs 0 immediately, no drained pulse, FSM in RUN after release.

Source files
------------

// File: rtl/pipe_cleaner_pkg.sv
// rtl/pipe_cleaner_pkg.sv - shared types and helpers for the elastic pipe cleaner
package pipe_cleaner_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } pc_state_t;

   localparam int STATS_W = 16;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_cleaner_stage.sv
// rtl/pipe_cleaner_stage.sv - one pipeline register stage: valid bit plus payload
module pipe_cleaner_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   // A loaded bubble only drops the valid bit; the payload is left as it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else if (clear) begin
         q_valid <= 1'b0;
      end else if (load) begin
         q_valid <= d_valid;
         if (d_valid) begin
            q_data <= d_data;
         end
      end
   end

endmodule

// File: rtl/pipe_cleaner.sv
// rtl/pipe_cleaner.sv - elastic bubble-squeezing pipeline with flush and drain FSM
// Optional flush statistics counter enabled by PIPE_CLEANER_STATS_EN.
module pipe_cleaner
   import pipe_cleaner_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         flush,
   input  logic                         drain_req,
   output logic                         drained,
   output logic [occ_width(DEPTH)-1:0]  occupancy,
   output logic                         empty,
   output logic                         full
`ifdef PIPE_CLEANER_STATS_EN
   ,
   output logic [STATS_W-1:0]           flushed_cnt
`endif
);

   localparam int OW = occ_width(DEPTH);

   logic [DEPTH-1:0] stage_valid;
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH:0]   ready;
   logic             accept;
   logic             deliver;
   logic [OW-1:0]    occ_next;
   pc_state_t        state;
   pc_state_t        state_next;

   // A stage may load whenever it is empty or everything downstream will move.
   always_comb begin
      ready[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready[i] = ~stage_valid[i] | ready[i+1];
      end
   end

   assign in_ready = ready[0] & (state == ST_RUN) & ~flush;
   assign accept   = in_valid & in_ready;
   assign deliver  = out_valid & out_ready;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (g == 0) begin : g_head
         assign src_valid = accept;
         assign src_data  = in_data;
      end else begin : g_body
         assign src_valid = stage_valid[g-1];
         assign src_data  = stage_data[g-1];
      end

      pipe_cleaner_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (ready[g]),
         .clear   (flush),
         .d_valid (src_valid),
         .d_data  (src_data),
         .q_valid (stage_valid[g]),
         .q_data  (stage_data[g])
      );
   end

   assign out_valid = stage_valid[DEPTH-1];
   assign out_data  = stage_data[DEPTH-1];

   always_comb begin
      occ_next = occupancy;
      if (flush) begin
         occ_next = '0;
      end else begin
         occ_next = occupancy + OW'(accept) - OW'(deliver);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else begin
         occupancy <= occ_next;
      end
   end

   assign empty = (occupancy == '0);
   assign full  = (occupancy == OW'(DEPTH));

   // DRAIN looks at the next occupancy so DONE lands the cycle after the last word leaves.
   always_comb begin
      state_next = state;
      drained    = 1'b0;
      case (state)
         ST_RUN: begin
            if (drain_req) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (occ_next == '0) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            drained    = 1'b1;
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

`ifdef PIPE_CLEANER_STATS_EN
   logic [STATS_W:0] flush_sum;

   // Words handed off during the flush cycle were delivered, not discarded.
   always_comb begin
      flush_sum = {1'b0, flushed_cnt} + (STATS_W+1)'(occupancy) - (STATS_W+1)'(deliver);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flushed_cnt <= '0;
      end else if (flush) begin
         flushed_cnt <= flush_sum[STATS_W] ? '1 : flush_sum[STATS_W-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_pipe_cleaner.sv
// tb/tb_pipe_cleaner.sv - directed scoreboard bench for pipe_cleaner at DEPTH=4
module tb_pipe_cleaner;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;
   logic             drain_req;
   logic             drained;
   logic [OW-1:0]    occupancy;
   logic             empty;
   logic             full;
`ifdef PIPE_CLEANER_STATS_EN
   logic [15:0]      flushed_cnt;
`endif

   int               n_assert = 0;
   int               n_fail = 0;
   int               cyc = 0;
   int               last_del_cyc = -1;
   logic [WIDTH-1:0] sb [$];

   pipe_cleaner #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .flush       (flush),
      .drain_req   (drain_req),
      .drained     (drained),
      .occupancy   (occupancy),
      .empty       (empty),
`ifdef PIPE_CLEANER_STATS_EN
      .flushed_cnt (flushed_cnt),
`endif
      .full        (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Handshakes are sampled on the falling edge, outputs checked 1 time unit after the rising edge.
   task automatic tick();
      logic [31:0] exp_w;
      @(negedge clk);
      if (out_valid && out_ready) begin
         exp_w = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD_BEEF;
         chk("sb_data", 32'(out_data), exp_w);
         last_del_cyc = cyc;
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (flush) sb.delete();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses;
      int bad;
      int dcyc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      drain_req = 1'b0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_drained", 32'(drained), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // latency and throughput
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      tick();
      in_data = 8'h22;
      tick();
      in_data = 8'h33;
      tick();
      in_valid = 1'b0;
      chk("lat_early", 32'(out_valid), 32'd0);
      chk("occ_peak", 32'(occupancy), 32'd3);
      tick();
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'h11);
      tick();
      chk("thru_data", 32'(out_data), 32'h22);
      tick();
      tick();
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_occ", 32'(occupancy), 32'd0);

      // fill while stalled
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'(8'h40 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("fill_accepted", 32'(sb.size()), 32'd4);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_occ", 32'(occupancy), 32'd4);
      out_ready = 1'b1;
      #1;
      chk("fill_ready_rise", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) tick();
      chk("fill_empty", 32'(empty), 32'd1);
      chk("fill_sb_drained", 32'(sb.size()), 32'd0);

      // bubble squeeze
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      in_valid = 1'b1;
      in_data  = 8'hBB;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("sq_occ", 32'(occupancy), 32'd2);
      chk("sq_full", 32'(full), 32'd0);
      chk("sq_head", 32'(out_data), 32'hAA);
      out_ready = 1'b1;
      tick();
      chk("sq_adj_valid", 32'(out_valid), 32'd1);
      chk("sq_adj_data", 32'(out_data), 32'hBB);
      tick();
      chk("sq_empty", 32'(empty), 32'd1);

      // flush with stalled output
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'(8'hC0 + i);
         tick();
      end
      in_data = 8'h99;
      flush   = 1'b1;
      #1;
      chk("flush_block", 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_occ", 32'(occupancy), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
`ifdef PIPE_CLEANER_STATS_EN
      chk("flush_cnt", 32'(flushed_cnt), 32'd3);
`endif
      tick();
      chk("flush_noacc", 32'(occupancy), 32'd0);

      // drain on an empty pipe
      out_ready = 1'b1;
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      chk("de_no_pulse", 32'(drained), 32'd0);
      chk("de_blocked", 32'(in_ready), 32'd0);
      tick();
      chk("de_pulse", 32'(drained), 32'd1);
      tick();
      chk("de_pulse_end", 32'(drained), 32'd0);
      chk("de_ready", 32'(in_ready), 32'd1);

      // drain with two words in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h61;
      tick();
      in_data = 8'h62;
      tick();
      in_valid  = 1'b0;
      drain_req = 1'b1;
      out_ready = 1'b1;
      tick();
      drain_req = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h77;
      #1;
      chk("dr_block", 32'(in_ready), 32'd0);
      pulses = 0;
      bad    = 0;
      dcyc   = -100;
      for (int i = 0; i < 15 && !(pulses > 0 && cyc == dcyc + 1); i++) begin
         tick();
         if (drained) begin
            pulses++;
            dcyc = cyc;
            if (in_ready) bad++;
         end else if (pulses == 0 && in_ready) begin
            bad++;
         end
      end
      chk("dr_pulses", 32'(pulses), 32'd1);
      chk("dr_pulse_cycle", 32'(dcyc), 32'(last_del_cyc + 1));
      chk("dr_blocked_all", 32'(bad), 32'd0);
      chk("dr_recover", 32'(in_ready), 32'd1);
      chk("dr_pulse_once", 32'(drained), 32'd0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) tick();
      chk("dr_empty", 32'(empty), 32'd1);
      chk("dr_sb", 32'(sb.size()), 32'd0);

      // async reset mid-drain
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      tick();
      in_data = 8'h5B;
      tick();
      in_valid  = 1'b0;
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      chk("rd_in_drain", 32'(in_ready), 32'd0);
      tick();
      chk("rd_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("rd_out_valid", 32'(out_valid), 32'd0);
      chk("rd_out_data", 32'(out_data), 32'd0);
      chk("rd_occ", 32'(occupancy), 32'd0);
      chk("rd_drained", 32'(drained), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rd_run", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (drained) pulses++;
      end
      chk("rd_no_pulse", 32'(pulses), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) tick();
      chk("rd_final_empty", 32'(empty), 32'd1);
      chk("rd_final_sb", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
